// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter sharing one decoded resource among 4 requesters.
// Holds each grant until the owner finishes, drops its request or hits HOLD_MAX.
module rr_decode_arbiter #(
   parameter int HOLD_MAX = 16,
   parameter int CNT_W    = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic [3:0] done,
   output logic       grant_en,
   output logic [1:0] grant_idx,
   output logic [3:0] grant_n,
   output logic       busy,
   output logic       timeout
);

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

   state_t           state;
   logic [1:0]       last;
   logic [CNT_W-1:0] hold_cnt;

   logic [1:0] pick;
   logic       pick_vld;
   logic [1:0] scan_k;
   logic       owner_done;
   logic       owner_req;
   logic       at_limit;
   logic       release_now;

   // Scan from the farthest candidate back to the nearest so the nearest
   // requester after 'last' is the one left standing.
   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      pick     = 2'd0;
      pick_vld = 1'b0;
      scan_k   = 2'd0;
      for (int i = 4; i >= 1; i--) begin
         scan_k = last + 2'(i);
         if (req[scan_k]) begin
            pick     = scan_k;
            pick_vld = 1'b1;
         end
      end
   end

   assign owner_done  = done[grant_idx];
   assign owner_req   = req[grant_idx];
   assign at_limit    = (HOLD_MAX != 0) && (hold_cnt == CNT_W'(HOLD_MAX - 1));
   assign release_now = owner_done | ~owner_req | at_limit;

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         grant_en  <= 1'b0;
         grant_idx <= 2'd0;
         busy      <= 1'b0;
         timeout   <= 1'b0;
         hold_cnt  <= '0;
         last      <= 2'd3;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  grant_idx <= pick;
                  grant_en  <= 1'b1;
                  hold_cnt  <= '0;
                  busy      <= 1'b1;
                  state     <= GRANT;
               end
            end
            GRANT: begin
               if (release_now) begin
                  grant_en <= 1'b0;
                  last     <= grant_idx;
                  timeout  <= at_limit & ~owner_done & owner_req;
                  state    <= RELEASE;
               end else if (int'(hold_cnt) < HOLD_MAX) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            RELEASE: begin
               // 'last' already points at the previous owner, so it only wins
               // again when nobody else is asking.
               if (pick_vld) begin
                  grant_idx <= pick;
                  grant_en  <= 1'b1;
                  hold_cnt  <= '0;
                  state     <= GRANT;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               grant_en <= 1'b0;
               busy     <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

   // Built from flops that reset asynchronously, so selects deassert at once on reset.
   assign grant_n = ~(4'b0001 << grant_idx) | {4{~grant_en}};

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Scoreboard bench for rr_decode_arbiter: a transaction-level model predicts each
// cycle's outputs into a queue, and a negedge monitor pops and compares.
module tb_rr_decode_arbiter;

   localparam int HM = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = 4'd0;
   logic [3:0] done = 4'd0;
   logic       grant_en;
   logic [1:0] grant_idx;
   logic [3:0] grant_n;
   logic       busy;
   logic       timeout;

   rr_decode_arbiter #(.HOLD_MAX(HM), .CNT_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .done(done),
      .grant_en(grant_en), .grant_idx(grant_idx), .grant_n(grant_n),
      .busy(busy), .timeout(timeout)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       en;
      logic [1:0] idx;
      logic [3:0] gn;
      logic       busy;
      logic       tmo;
   } exp_t;

   exp_t expq[$];
   int   n_vec = 0;
   int   n_err = 0;
   bit   mon_en = 0;
   int   grants_seen[$];
   logic prev_en = 1'b0;

   // Reference model: who owns the resource, for how many cycles so far,
   // whether this is the dead turnaround cycle, and who owned it last.
   int m_owner = -1;
   int m_len   = 0;
   int m_last  = 3;
   bit m_dead  = 0;
   bit m_tmo   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e.en   = (m_owner >= 0);
      e.idx  = e.en ? 2'(m_owner) : 2'd0;
      e.gn   = e.en ? ~(4'b0001 << e.idx) : 4'hF;
      e.busy = e.en | m_dead;
      e.tmo  = m_tmo;
      return e;
   endfunction

   function automatic int rr_pick(input logic [3:0] r);
      for (int off = 1; off <= 4; off++) begin
         if (r[(m_last + off) % 4]) return (m_last + off) % 4;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1; m_len = 0; m_last = 3; m_dead = 0; m_tmo = 0;
   endtask

   task automatic model_step(input logic [3:0] r, input logic [3:0] d);
      int w;
      bit lim;
      m_tmo = 0;
      if (m_owner >= 0) begin
         lim = (HM != 0) && (m_len == HM);
         if (d[m_owner] || !r[m_owner] || lim) begin
            m_tmo   = lim && !d[m_owner] && r[m_owner];
            m_last  = m_owner;
            m_owner = -1;
            m_dead  = 1;
         end else begin
            m_len++;
         end
      end else begin
         w = rr_pick(r);
         m_dead = 0;
         if (w >= 0) begin
            m_owner = w;
            m_len   = 1;
         end
      end
   endtask

   task automatic drive(input logic [3:0] r, input logic [3:0] d);
      @(negedge clk);
      req  = r;
      done = d;
      model_step(r, d);
      expq.push_back(model_out());
   endtask

   // Monitor: compares the DUT against the oldest queued prediction each cycle.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         n_vec++;
         if (expq.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard: queue empty at t=%0t", $time);
         end else begin
            e = expq.pop_front();
            if (grant_en !== e.en || grant_n !== e.gn || busy !== e.busy ||
                timeout !== e.tmo || (e.en && grant_idx !== e.idx)) begin
               n_err++;
               $display("FAIL cycle t=%0t: got en=%b idx=%0d gn=%b busy=%b tmo=%b expected en=%b idx=%0d gn=%b busy=%b tmo=%b",
                        $time, grant_en, grant_idx, grant_n, busy, timeout,
                        e.en, e.idx, e.gn, e.busy, e.tmo);
            end
         end
         if (grant_en && !prev_en) grants_seen.push_back(int'(grant_idx));
         prev_en = grant_en;
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, " grant_n"},  32'(grant_n),  32'hF);
      check({tag, " grant_en"}, 32'(grant_en), 32'h0);
      check({tag, " busy"},     32'(busy),     32'h0);
      check({tag, " timeout"},  32'(timeout),  32'h0);
   endtask

   task automatic restart_scoreboard();
      @(negedge clk);
      expq.delete();
      model_reset();
      req  = 4'd0;
      done = 4'd0;
      expq.push_back(model_out());
      #1;
      rst_n   = 1'b1;
      prev_en = 1'b0;
      mon_en  = 1;
   endtask

   task automatic run_all_request(input int cycles);
      logic [3:0] d;
      for (int i = 0; i < cycles; i++) begin
         d = (m_owner >= 0 && m_len == 1) ? 4'(4'b0001 << m_owner) : 4'd0;
         drive(4'hF, d);
      end
   endtask

   initial begin
      int exp_order[5] = '{0, 1, 2, 3, 0};
      logic [3:0] r;
      logic [3:0] d;
      int guard;

      #3;
      check_reset_outputs("power-on reset");
      restart_scoreboard();

      // All four requesting, each owner finishes in its first grant cycle.
      grants_seen.delete();
      run_all_request(10);
      drive(4'd0, 4'd0);
      drive(4'd0, 4'd0);
      check("rr order count", 32'(grants_seen.size() >= 5), 32'h1);
      for (int i = 0; i < 5; i++) begin
         if (i < grants_seen.size()) check($sformatf("rr order[%0d]", i), 32'(grants_seen[i]), 32'(exp_order[i]));
      end

      // Single requester 2 finishing with a done pulse on its fifth cycle.
      for (int i = 0; i < 4; i++) drive(4'b0100, 4'd0);
      drive(4'b0100, 4'b0100);
      for (int i = 0; i < 3; i++) drive(4'd0, 4'd0);

      // Owner 3 finishes while 0 and 2 wait: 0 then 2.
      drive(4'b1000, 4'd0);
      drive(4'b1000, 4'd0);
      drive(4'b0101, 4'b1000);
      drive(4'b0101, 4'd0);
      drive(4'b0101, 4'b0001);
      drive(4'b0100, 4'd0);
      drive(4'b0100, 4'd0);
      drive(4'b0100, 4'b0100);
      drive(4'd0, 4'd0);
      drive(4'd0, 4'd0);

      // Owner 1 drops its request while a non-owner pulses done.
      drive(4'b0010, 4'd0);
      drive(4'b0010, 4'd0);
      drive(4'b0100, 4'b0100);
      drive(4'b0100, 4'd0);
      drive(4'b0100, 4'b0100);
      drive(4'd0, 4'd0);
      drive(4'd0, 4'd0);

      // Requester 1 never finishes: forced release every HM cycles.
      for (int i = 0; i < 12; i++) drive(4'b0010, 4'd0);
      guard = 0;
      while (m_owner < 0 && guard < 10) begin
         drive(4'b0010, 4'd0);
         guard++;
      end

      // Asynchronous reset in the middle of a grant.
      @(posedge clk);
      #2;
      mon_en = 0;
      check("pre-reset grant_en", 32'(grant_en), 32'h1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid-grant reset");
      restart_scoreboard();
      grants_seen.delete();
      run_all_request(4);
      drive(4'd0, 4'd0);
      drive(4'd0, 4'd0);
      check("post-reset first grant count", 32'(grants_seen.size() >= 1), 32'h1);
      if (grants_seen.size() >= 1) check("post-reset first grant idx", 32'(grants_seen[0]), 32'h0);

      // Randomised traffic.
      r = 4'd0;
      for (int i = 0; i < 800; i++) begin
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
         end
         d = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
         drive(r, d);
      end
      for (int i = 0; i < 3; i++) drive(4'd0, 4'd0);

      @(negedge clk);
      #1;
      mon_en = 0;
      check("scoreboard drained", 32'(expq.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
